cordic_host_ctrl: RTL and testbench
===================================

Name: cordic_host_ctrl

Overview:
Initiator side of the CORDIC job interface. It accepts CORDIC jobs from an upstream valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the CORDIC engine's valid/func/data port, waits for done, and returns tagged results on a downstream valid/ready stream. It sits between the systolic-array control path and the CORDIC top, and guards against a hung engine with a timeout.

Parameters:
- DATA_W, 48, CORDIC data word width: {x[47:32], y[31:16], z[15:0]}, each 16-bit two's complement.
- FUNC_W, 2, function-select width (00 rotate, 01 vector, 10/11 reserved, passed through unmodified).
- TAG_W, 4, job tag width, returned unchanged with the result.
- FIFO_DEPTH, 4, job FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before an error result is returned; minimum 2.

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  upstream job valid.
- o_req_ready  out  1  job FIFO can accept.
- i_req_func  in  FUNC_W  job function.
- i_req_data  in  DATA_W  job operands.
- i_req_tag  in  TAG_W  job tag.
- o_cdc_valid  out  1  one-cycle start pulse to the CORDIC engine.
- o_cdc_func  out  FUNC_W  function to the engine.
- o_cdc_data  out  DATA_W  operands to the engine.
- i_cdc_done  in  1  engine result valid (single-cycle pulse).
- i_cdc_data  in  DATA_W  engine result.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  downstream accepts result.
- o_rsp_data  out  DATA_W  result.
- o_rsp_tag  out  TAG_W  tag of the job.
- o_rsp_err  out  1  1 = timeout, data forced to 0.
- o_busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (i_rst=1 at an edge):
  - FIFO is emptied, FSM goes to IDLE, timer is cleared.
  - All outputs are 0, including o_req_ready while i_rst=1.
  - o_req_ready rises the first cycle after i_rst deasserts.
  - Reset mid-job abandons the job; any later i_cdc_done is ignored because the FSM is in IDLE.
- FIFO:
  - A push happens when i_req_valid && o_req_ready.
  - o_req_ready = !full, registered state only; it does not depend on the same-cycle pop.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
  - A push and a pop in the same cycle are both performed. Occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the job registers (func, data, tag) and go to ISSUE. Otherwise stay.
  - ISSUE: o_cdc_valid=1 for exactly this cycle, with o_cdc_func/o_cdc_data driven from the job registers. Clear the timer. Go to WAIT.
  - WAIT:
    - The timer increments each cycle.
    - If i_cdc_done=1: capture i_cdc_data, set err=0, go to RESP.
    - Else if timer == TIMEOUT_CYCLES-1: data=0, err=1, go to RESP.
    - If done and timeout coincide, done wins (err=0).
  - RESP: o_rsp_valid=1 with data/tag/err held stable. On i_rsp_ready, go to IDLE.
- o_cdc_func/o_cdc_data are held at the last job value outside ISSUE. They are 0 after reset.
- i_cdc_done is ignored in IDLE, ISSUE and RESP (stale or spurious pulse). No state change.
- Latency:
  - Push at edge t with FSM in IDLE and FIFO empty: pop at t+1, o_cdc_valid high during cycle t+1..t+2.
  - Done sampled at edge d gives o_rsp_valid high from d.
  - Minimum response-to-next-issue gap is 2 cycles (RESP→IDLE→ISSUE).
- Ordering: responses are returned strictly in acceptance order. Exactly one response per accepted job.
- o_busy = (state != IDLE) || !empty.

Test Plan:
- Single job: reset 4 cycles, push func=00, data=48'h2000_0000_1000, tag=3. Engine model asserts done 12 cycles after start with data=48'h1234_5678_9ABC → exactly one o_cdc_valid pulse; o_rsp_valid with data 48'h1234_5678_9ABC, tag 3, err 0.
- Backpressure/full: hold i_rsp_ready=0, push 6 jobs back-to-back with tags 0..5 → o_req_ready drops after 4 FIFO pushes plus 1 in flight. With ready=1, responses come out tags 0..5 in order, none lost or duplicated.
- Timeout: engine never asserts done → after 64 WAIT cycles, o_rsp_valid with err=1, data=0, correct tag; the next queued job is issued normally.
- Done on the timeout cycle: done at WAIT count 63 → err=0, captured data returned.
- Spurious done: pulse i_cdc_done while IDLE and while in RESP → no response generated, held response data unchanged.
- Reset mid-WAIT with 2 jobs queued: assert i_rst 1 cycle, then the engine asserts late done → no response, FIFO empty, o_busy=0, o_req_ready=1 the next cycle.

Source files
------------

// File: rtl/cordic_host_ctrl.sv
// Host-side controller for the CORDIC engine: buffers upstream jobs, issues them
// one at a time, waits for done (or times out) and returns tagged results in order.
module cordic_host_ctrl #(
  parameter int unsigned DATA_W         = 48,
  parameter int unsigned FUNC_W         = 2,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [FUNC_W-1:0] i_req_func,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic [TAG_W-1:0]  i_req_tag,
  output logic              o_cdc_valid,
  output logic [FUNC_W-1:0] o_cdc_func,
  output logic [DATA_W-1:0] o_cdc_data,
  input  logic              i_cdc_done,
  input  logic [DATA_W-1:0] i_cdc_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [TAG_W-1:0]  o_rsp_tag,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [FUNC_W-1:0] fifo_func [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [TAG_W-1:0]  fifo_tag  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic             empty, empty_d, full_d, push, pop;
  logic             take_done, take_timeout;
  logic [TMR_W-1:0] timer_q;
  logic [TAG_W-1:0] job_tag_q;

  // FIFO bookkeeping; ready/busy are registered from next-state occupancy
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = i_req_valid && o_req_ready;
  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign empty_d  = (wr_ptr_d == rd_ptr_d);
  assign full_d   = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                    (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);

  // Next-state logic; done has priority over the timeout on the same cycle
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_cdc_done) begin
          take_done = 1'b1;
          state_d   = ST_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          take_timeout = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Storage is not reset; pointer reset alone empties the FIFO
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_func[wr_ptr_q[ADDR_W-1:0]] <= i_req_func;
      fifo_data[wr_ptr_q[ADDR_W-1:0]] <= i_req_data;
      fifo_tag[wr_ptr_q[ADDR_W-1:0]]  <= i_req_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      job_tag_q   <= '0;
      o_req_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_cdc_valid <= 1'b0;
      o_cdc_func  <= '0;
      o_cdc_data  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_tag   <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      o_req_ready <= !full_d;
      o_busy      <= (state_d != ST_IDLE) || !empty_d;
      o_cdc_valid <= (state_d == ST_ISSUE);
      o_rsp_valid <= (state_d == ST_RESP);

      // Job registers double as the engine operand outputs and hold between jobs
      if (pop) begin
        o_cdc_func <= fifo_func[rd_ptr_q[ADDR_W-1:0]];
        o_cdc_data <= fifo_data[rd_ptr_q[ADDR_W-1:0]];
        job_tag_q  <= fifo_tag[rd_ptr_q[ADDR_W-1:0]];
      end

      if (state_q == ST_ISSUE)     timer_q <= '0;
      else if (state_q == ST_WAIT) timer_q <= timer_q + TMR_W'(1);

      if (take_done) begin
        o_rsp_data <= i_cdc_data;
        o_rsp_tag  <= job_tag_q;
        o_rsp_err  <= 1'b0;
      end else if (take_timeout) begin
        o_rsp_data <= '0;
        o_rsp_tag  <= job_tag_q;
        o_rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_host_ctrl.sv
// Bench for cordic_host_ctrl: directed and random jobs against a queue-based
// reference of accepted jobs, with a delay-scheduled CORDIC engine stand-in.
module tb_cordic_host_ctrl;

  localparam int unsigned DATA_W         = 48;
  localparam int unsigned FUNC_W         = 2;
  localparam int unsigned TAG_W          = 4;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [FUNC_W-1:0] i_req_func = '0;
  logic [DATA_W-1:0] i_req_data = '0;
  logic [TAG_W-1:0]  i_req_tag = '0;
  logic              o_cdc_valid;
  logic [FUNC_W-1:0] o_cdc_func;
  logic [DATA_W-1:0] o_cdc_data;
  logic              i_cdc_done;
  logic [DATA_W-1:0] i_cdc_data;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [DATA_W-1:0] o_rsp_data;
  logic [TAG_W-1:0]  o_rsp_tag;
  logic              o_rsp_err;
  logic              o_busy;

  always #5 i_clk = ~i_clk;

  cordic_host_ctrl #(
    .DATA_W(DATA_W), .FUNC_W(FUNC_W), .TAG_W(TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_func(i_req_func), .i_req_data(i_req_data), .i_req_tag(i_req_tag),
    .o_cdc_valid(o_cdc_valid), .o_cdc_func(o_cdc_func), .o_cdc_data(o_cdc_data),
    .i_cdc_done(i_cdc_done), .i_cdc_data(i_cdc_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag), .o_rsp_err(o_rsp_err),
    .o_busy(o_busy)
  );

  // delay < 0 means the engine never answers this job
  typedef struct {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    int                delay;
    logic [DATA_W-1:0] res;
    int                idx;
  } job_t;

  job_t stim_q[$];
  job_t exp_q[$];
  int   n_checks = 0, n_errors = 0, n_acc = 0, n_rsp = 0, sched_w = 0;
  int   rsp_mode = 1;
  bit   gap_rand = 1'b0;

  int                sched_delay [256];
  logic [DATA_W-1:0] sched_res   [256];
  logic [FUNC_W-1:0] log_func    [256];
  logic [DATA_W-1:0] log_data    [256];

  int                eng_n = 0, eng_cnt = 0;
  logic              eng_pend = 1'b0, eng_done = 1'b0;
  logic [DATA_W-1:0] eng_cur = '0, eng_out = '0;
  logic              spur_done = 1'b0;
  logic [DATA_W-1:0] spur_data = '0;

  assign i_cdc_done = eng_done | spur_done;
  assign i_cdc_data = spur_done ? spur_data : eng_out;

  // Engine stand-in: logs each start pulse, answers after the scheduled delay
  always @(posedge i_clk) begin
    eng_done <= 1'b0;
    if (eng_pend) begin
      if (eng_cnt == 0) begin
        eng_done <= 1'b1;
        eng_out  <= eng_cur;
        eng_pend <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
    if (o_cdc_valid) begin
      log_func[eng_n[7:0]] <= o_cdc_func;
      log_data[eng_n[7:0]] <= o_cdc_data;
      if (sched_delay[eng_n[7:0]] >= 0) begin
        eng_pend <= 1'b1;
        eng_cnt  <= sched_delay[eng_n[7:0]];
        eng_cur  <= sched_res[eng_n[7:0]];
      end
      eng_n <= eng_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic add_job(input logic [FUNC_W-1:0] f, input logic [DATA_W-1:0] d,
                         input logic [TAG_W-1:0] t, input int dly, input logic [DATA_W-1:0] r);
    job_t j;
    j.func = f; j.data = d; j.tag = t; j.delay = dly; j.res = r; j.idx = 0;
    stim_q.push_back(j);
  endtask

  // One clock of traffic: offer the next job, apply rsp_ready, then account for
  // the handshakes and compare any returned response against the reference.
  task automatic step();
    logic acc, got, r_err;
    logic [DATA_W-1:0] r_data, e_data;
    logic [TAG_W-1:0] r_tag;
    logic e_err;
    job_t j;
    if (stim_q.size() > 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
      i_req_valid = 1'b1;
      i_req_func  = stim_q[0].func;
      i_req_data  = stim_q[0].data;
      i_req_tag   = stim_q[0].tag;
    end else begin
      i_req_valid = 1'b0;
    end
    case (rsp_mode)
      0:       i_rsp_ready = 1'b0;
      1:       i_rsp_ready = 1'b1;
      default: i_rsp_ready = 1'($urandom_range(0, 1));
    endcase
    acc    = i_req_valid && o_req_ready;
    got    = o_rsp_valid && i_rsp_ready;
    r_data = o_rsp_data;
    r_tag  = o_rsp_tag;
    r_err  = o_rsp_err;
    tick();
    if (acc) begin
      j = stim_q.pop_front();
      j.idx = sched_w;
      sched_delay[sched_w[7:0]] = j.delay;
      sched_res[sched_w[7:0]]   = j.res;
      sched_w++;
      n_acc++;
      exp_q.push_back(j);
    end
    if (got) begin
      n_rsp++;
      chk("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        j = exp_q.pop_front();
        // Done lands in WAIT cycle delay+1; timeout fires in WAIT cycle TIMEOUT-1
        e_err  = (j.delay < 0) || (j.delay + 1 > int'(TIMEOUT_CYCLES) - 1);
        e_data = e_err ? '0 : j.res;
        chk("rsp_tag",  64'(r_tag),  64'(j.tag));
        chk("rsp_data", 64'(r_data), 64'(e_data));
        chk("rsp_err",  64'(r_err),  64'(e_err));
        chk("cdc_func", 64'(log_func[j.idx[7:0]]), 64'(j.func));
        chk("cdc_data", 64'(log_data[j.idx[7:0]]), 64'(j.data));
      end
    end
  endtask

  task automatic run(input int want, input int budget);
    int start;
    int cyc;
    start = n_rsp;
    cyc   = 0;
    while ((n_rsp - start) < want && cyc < budget) begin
      step();
      cyc++;
    end
    chk("rsp_count", 64'(n_rsp - start), 64'(want));
  endtask

  initial begin
    int base, base_acc, base_rsp, cyc;
    logic [DATA_W-1:0] held;

    // Reset
    idle_in();
    i_rst = 1'b1;
    repeat (4) tick();
    chk("rst_req_ready", 64'(o_req_ready), 64'(0));
    chk("rst_cdc_valid", 64'(o_cdc_valid), 64'(0));
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("rst_busy",      64'(o_busy),      64'(0));
    chk("rst_cdc_data",  64'(o_cdc_data),  64'(0));
    chk("rst_rsp_data",  64'(o_rsp_data),  64'(0));
    i_rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(o_req_ready), 64'(1));

    // Single job with exact issue latency
    base = eng_n;
    rsp_mode = 1;
    add_job(2'b00, 48'h2000_0000_1000, 4'd3, 11, 48'h1234_5678_9ABC);
    step();
    chk("single_valid_t0", 64'(o_cdc_valid), 64'(0));
    chk("single_busy",     64'(o_busy),      64'(1));
    step();
    chk("single_valid_t1", 64'(o_cdc_valid), 64'(1));
    step();
    chk("single_valid_t2", 64'(o_cdc_valid), 64'(0));
    run(1, 100);
    chk("single_issues", 64'(eng_n - base), 64'(1));
    chk("single_idle_busy", 64'(o_busy), 64'(0));

    // Backpressure: 4 queued plus 1 in flight, the sixth is held off
    base = eng_n;
    base_acc = n_acc;
    rsp_mode = 0;
    for (int t = 0; t < 6; t++)
      add_job(2'($urandom_range(0, 1)), rnd48(), 4'(t), 3, rnd48());
    repeat (20) step();
    chk("bp_accepted", 64'(n_acc - base_acc), 64'(5));
    chk("bp_ready",    64'(o_req_ready),      64'(0));
    chk("bp_rsp_hold", 64'(o_rsp_valid),      64'(1));
    rsp_mode = 1;
    run(6, 400);
    chk("bp_issues",  64'(eng_n - base),  64'(6));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Timeout then a normal job; done on the last WAIT cycle and one past it
    add_job(2'b01, rnd48(), 4'd7, -1, rnd48());
    add_job(2'b00, rnd48(), 4'd8, 4, rnd48());
    run(2, 300);
    add_job(2'b00, rnd48(), 4'd9, int'(TIMEOUT_CYCLES) - 2, rnd48());
    add_job(2'b01, rnd48(), 4'd10, int'(TIMEOUT_CYCLES) - 1, rnd48());
    add_job(2'b11, rnd48(), 4'd11, 0, rnd48());
    run(3, 400);

    // Spurious done while idle
    idle_in();
    spur_data = rnd48();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    base_rsp = n_rsp;
    repeat (5) step();
    chk("spur_idle_rsp",  64'(n_rsp - base_rsp), 64'(0));
    chk("spur_idle_busy", 64'(o_busy),           64'(0));

    // Spurious done while a response is held
    rsp_mode = 0;
    add_job(2'b10, rnd48(), 4'd12, 2, rnd48());
    cyc = 0;
    while (!o_rsp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("spur_resp_reached", 64'(o_rsp_valid), 64'(1));
    held = o_rsp_data;
    idle_in();
    spur_data = ~held;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    chk("spur_resp_valid", 64'(o_rsp_valid), 64'(1));
    chk("spur_resp_data",  64'(o_rsp_data),  64'(held));
    chk("spur_resp_err",   64'(o_rsp_err),   64'(0));
    rsp_mode = 1;
    run(1, 10);
    base_rsp = n_rsp;
    repeat (5) step();
    chk("spur_resp_single", 64'(n_rsp - base_rsp), 64'(0));

    // Random traffic with random gaps and random downstream stalls
    rsp_mode = 2;
    gap_rand = 1'b1;
    for (int k = 0; k < 12; k++)
      add_job(2'($urandom_range(0, 3)), rnd48(), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 20)), rnd48());
    run(12, 3000);
    gap_rand = 1'b0;

    // Reset mid-WAIT with two jobs queued; the engine's late done must vanish
    rsp_mode = 1;
    base = eng_n;
    add_job(2'b00, rnd48(), 4'd1, 40, rnd48());
    add_job(2'b01, rnd48(), 4'd2, 3, rnd48());
    add_job(2'b00, rnd48(), 4'd4, 3, rnd48());
    cyc = 0;
    while (eng_n == base && cyc < 50) begin
      step();
      cyc++;
    end
    repeat (5) step();
    chk("rstmid_all_queued", 64'(stim_q.size()), 64'(0));
    chk("rstmid_busy_pre",   64'(o_busy),        64'(1));
    idle_in();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    sched_w = eng_n;
    chk("rstmid_ready_in_rst", 64'(o_req_ready), 64'(0));
    chk("rstmid_busy_rst",     64'(o_busy),      64'(0));
    tick();
    chk("rstmid_ready_after",  64'(o_req_ready), 64'(1));
    chk("rstmid_busy_after",   64'(o_busy),      64'(0));
    base_rsp = n_rsp;
    repeat (50) step();
    chk("rstmid_late_done_seen", 64'(eng_pend),           64'(0));
    chk("rstmid_no_rsp",         64'(n_rsp - base_rsp),   64'(0));
    chk("rstmid_busy_end",       64'(o_busy),             64'(0));
    add_job(2'b01, rnd48(), 4'd5, 2, rnd48());
    run(1, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
